// File: rtl/mmio_gpio_pkg.sv
// Shared constants for the memory-mapped GPIO bank: register offsets
// within a channel window and the per-channel address stride.
package mmio_gpio_pkg;

    // Each channel owns an 8-byte window; the low address bits pick the register.
    localparam int ADDR_STRIDE = 8;
    localparam int REG_BITS    = $clog2(ADDR_STRIDE);

    localparam logic [2:0] REG_OUT = 3'd0;
    localparam logic [2:0] REG_DIR = 3'd1;
    localparam logic [2:0] REG_IN  = 3'd2;
    localparam logic [2:0] REG_EVT = 3'd3;
    localparam logic [2:0] REG_IEN = 3'd4;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop pin synchroniser plus a delay stage for rising-edge detection.
// Edge reports are held off until the delay stage contains a pin sample
// taken after reset, so a pin that is already high at reset release is
// not mistaken for a fresh 0->1 transition.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_out
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] s3_q, s3_d;
    logic [2:0]       arm_q, arm_d;

    // Next state of the shift chain and of the post-reset arming pipeline.
    always_comb begin
        s1_d  = pin_in;
        s2_d  = s1_q;
        s3_d  = s2_q;
        arm_d = {arm_q[1:0], 1'b1};
    end

    // Synchroniser, delay and arming flops with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q  <= {WIDTH{1'b0}};
            s2_q  <= {WIDTH{1'b0}};
            s3_q  <= {WIDTH{1'b0}};
            arm_q <= 3'b000;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            arm_q <= arm_d;
        end
    end

    assign sync_out = s2_q;
    assign rise_out = s2_q & ~s3_q & {WIDTH{arm_q[2]}};

endmodule

// File: rtl/mmio_gpio_bank.sv
// Bank of CHANNELS GPIO channels on a shared tri-state processor bus.
// Per channel: OUT, DIR, IN (synchronised pins), EVT (sticky rising-edge
// flags, write-1-to-clear) and IEN. irq is a registered OR of EVT & IEN.
module mmio_gpio_bank
    import mmio_gpio_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0000_F000,
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    inout  wire  [63:0]               data,
    input  logic [63:0]               address,
    input  logic                      read,
    input  logic                      write,
    input  logic [CHANNELS*WIDTH-1:0] gpio_in,
    output logic [CHANNELS*WIDTH-1:0] gpio_out,
    output logic [CHANNELS*WIDTH-1:0] gpio_oe,
    output logic                      irq
);

    localparam int CHW = 64 - REG_BITS;

    logic [WIDTH-1:0] out_q [CHANNELS];
    logic [WIDTH-1:0] out_d [CHANNELS];
    logic [WIDTH-1:0] dir_q [CHANNELS];
    logic [WIDTH-1:0] dir_d [CHANNELS];
    logic [WIDTH-1:0] evt_q [CHANNELS];
    logic [WIDTH-1:0] evt_d [CHANNELS];
    logic [WIDTH-1:0] ien_q [CHANNELS];
    logic [WIDTH-1:0] ien_d [CHANNELS];
    logic [WIDTH-1:0] sync_s [CHANNELS];
    logic [WIDTH-1:0] rise_s [CHANNELS];
    logic             irq_q, irq_d;

    logic [63:0]         offset_s;
    logic [CHW-1:0]      chan_s;
    logic [REG_BITS-1:0] reg_s;
    logic                hit_s;
    logic                wr_hit_s;
    logic                rd_drive_s;
    logic [WIDTH-1:0]    wdata_s;
    logic [63:0]         rdata_s;
    logic                unused_data_s;

    // Address decode; addresses below the base never hit, so there is no wrap.
    always_comb begin
        offset_s   = address - BASE_ADDR;
        chan_s     = offset_s[63:REG_BITS];
        reg_s      = offset_s[REG_BITS-1:0];
        hit_s      = (address >= BASE_ADDR) && (chan_s < CHW'(CHANNELS)) && (reg_s <= REG_IEN);
        wr_hit_s   = write && hit_s;
        rd_drive_s = read && !write && hit_s;
        wdata_s    = data[WIDTH-1:0];
    end

    // Read mux: gather the selected channel's registers, then pick by offset.
    always_comb begin
        logic [WIDTH-1:0] sel_out_s, sel_dir_s, sel_in_s, sel_evt_s, sel_ien_s;
        sel_out_s = {WIDTH{1'b0}};
        sel_dir_s = {WIDTH{1'b0}};
        sel_in_s  = {WIDTH{1'b0}};
        sel_evt_s = {WIDTH{1'b0}};
        sel_ien_s = {WIDTH{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            sel_out_s = sel_out_s | ((chan_s == CHW'(c)) ? out_q[c]  : {WIDTH{1'b0}});
            sel_dir_s = sel_dir_s | ((chan_s == CHW'(c)) ? dir_q[c]  : {WIDTH{1'b0}});
            sel_in_s  = sel_in_s  | ((chan_s == CHW'(c)) ? sync_s[c] : {WIDTH{1'b0}});
            sel_evt_s = sel_evt_s | ((chan_s == CHW'(c)) ? evt_q[c]  : {WIDTH{1'b0}});
            sel_ien_s = sel_ien_s | ((chan_s == CHW'(c)) ? ien_q[c]  : {WIDTH{1'b0}});
        end
        rdata_s = 64'd0;
        case (reg_s)
            REG_OUT: rdata_s[WIDTH-1:0] = sel_out_s;
            REG_DIR: rdata_s[WIDTH-1:0] = sel_dir_s;
            REG_IN:  rdata_s[WIDTH-1:0] = sel_in_s;
            REG_EVT: rdata_s[WIDTH-1:0] = sel_evt_s;
            REG_IEN: rdata_s[WIDTH-1:0] = sel_ien_s;
            default: rdata_s = 64'd0;
        endcase
    end

    assign data          = rd_drive_s ? rdata_s : {64{1'bz}};
    assign unused_data_s = ^data;

    // Register next-state: bus writes, W1C on EVT with edge-set winning, irq OR.
    always_comb begin
        logic [WIDTH-1:0] clr_mask_s;
        irq_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_d[c]   = out_q[c];
            dir_d[c]   = dir_q[c];
            ien_d[c]   = ien_q[c];
            clr_mask_s = {WIDTH{1'b0}};
            if (wr_hit_s && (chan_s == CHW'(c))) begin
                case (reg_s)
                    REG_OUT: out_d[c]   = wdata_s;
                    REG_DIR: dir_d[c]   = wdata_s;
                    REG_EVT: clr_mask_s = wdata_s;
                    REG_IEN: ien_d[c]   = wdata_s;
                    default: clr_mask_s = {WIDTH{1'b0}};
                endcase
            end else begin
                clr_mask_s = {WIDTH{1'b0}};
            end
            evt_d[c] = (evt_q[c] & ~clr_mask_s) | rise_s[c];
            irq_d    = irq_d | (|(evt_q[c] & ien_q[c]));
        end
    end

    // State registers; reset overrides any bus write or detected edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_q[c] <= {WIDTH{1'b0}};
                dir_q[c] <= {WIDTH{1'b0}};
                evt_q[c] <= {WIDTH{1'b0}};
                ien_q[c] <= {WIDTH{1'b0}};
            end
            irq_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                out_q[c] <= out_d[c];
                dir_q[c] <= dir_d[c];
                evt_q[c] <= evt_d[c];
                ien_q[c] <= ien_d[c];
            end
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

    for (genvar gv = 0; gv < CHANNELS; gv++) begin : g_chan
        gpio_sync_edge #(
            .WIDTH (WIDTH)
        ) u_sync (
            .clock    (clock),
            .reset    (reset),
            .pin_in   (gpio_in[gv*WIDTH +: WIDTH]),
            .sync_out (sync_s[gv]),
            .rise_out (rise_s[gv])
        );
        assign gpio_out[gv*WIDTH +: WIDTH] = out_q[gv];
        assign gpio_oe[gv*WIDTH +: WIDTH]  = dir_q[gv];
    end

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// Bench for mmio_gpio_bank: directed bus/pin stimulus, a history-based
// model of the bank compared on every falling edge, and literal checks.
module tb_mmio_gpio_bank;

    localparam int          CH   = 4;
    localparam int          W    = 8;
    localparam logic [63:0] BASE = 64'h0000_0000_0000_F000;

    logic            clock;
    logic            reset;
    wire  [63:0]     data;
    logic [63:0]     address;
    logic            read;
    logic            write;
    logic [CH*W-1:0] gpio_in;
    logic [CH*W-1:0] gpio_out;
    logic [CH*W-1:0] gpio_oe;
    logic            irq;

    logic [63:0] tb_wdata;
    logic        tb_drive;
    assign data = tb_drive ? tb_wdata : {64{1'bz}};

    int total = 0;
    int bad   = 0;

    mmio_gpio_bank #(
        .BASE_ADDR (BASE),
        .CHANNELS  (CH),
        .WIDTH     (W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data     (data),
        .address  (address),
        .read     (read),
        .write    (write),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Undriven bus: accept a true Z or the value an undriven net resolves to.
    task automatic chk_hiz(input string name, input logic [63:0] act);
        total++;
        if (!((act === {64{1'bz}}) || (act === 64'd0))) begin
            bad++;
            $display("FAIL %s act=%h exp=high-Z", name, act);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]    m_out [CH];
    logic [W-1:0]    m_dir [CH];
    logic [W-1:0]    m_evt [CH];
    logic [W-1:0]    m_ien [CH];
    logic [CH*W-1:0] h1, h2, h3;    // pin samples from the last three edges
    int              m_cnt;         // edges since reset was released
    logic            m_irq;
    bit              m_valid = 1'b0;

    function automatic void decode(input logic [63:0] a, output bit hit, output int ch, output int rg);
        logic [63:0] off;
        hit = 1'b0;
        ch  = 0;
        rg  = 0;
        if (a >= BASE) begin
            off = a - BASE;
            if ((off / 8 < CH) && (off % 8 <= 4)) begin
                hit = 1'b1;
                ch  = int'(off / 8);
                rg  = int'(off % 8);
            end
        end
    endfunction

    always @(posedge clock) begin
        bit              hit;
        int              ch, rg;
        logic [CH*W-1:0] rise;
        logic            irq_n;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_out[c] = '0; m_dir[c] = '0; m_evt[c] = '0; m_ien[c] = '0;
            end
            h1 = '0; h2 = '0; h3 = '0;
            m_cnt   = 0;
            m_irq   = 1'b0;
            m_valid = 1'b1;
        end else begin
            irq_n = 1'b0;
            for (int c = 0; c < CH; c++) irq_n = irq_n | (|(m_evt[c] & m_ien[c]));
            m_cnt++;
            // A 0->1 seen two samples back; only trusted once both samples postdate reset.
            rise = (m_cnt >= 4) ? (h2 & ~h3) : '0;
            h3 = h2; h2 = h1; h1 = gpio_in;
            decode(address, hit, ch, rg);
            if (write && hit) begin
                case (rg)
                    0: m_out[ch] = data[W-1:0];
                    1: m_dir[ch] = data[W-1:0];
                    3: m_evt[ch] = m_evt[ch] & ~data[W-1:0];
                    4: m_ien[ch] = data[W-1:0];
                    default: ;
                endcase
            end
            for (int c = 0; c < CH; c++) m_evt[c] = m_evt[c] | rise[c*W +: W];
            m_irq = irq_n;
        end
    end

    // Compare every falling edge against the model.
    always @(negedge clock) begin
        bit              hit;
        int              ch, rg;
        logic [CH*W-1:0] eo, ee;
        logic [63:0]     ed;
        if (m_valid) begin
            for (int c = 0; c < CH; c++) begin
                eo[c*W +: W] = m_out[c];
                ee[c*W +: W] = m_dir[c];
            end
            chk("m_gpio_out", 64'(gpio_out), 64'(eo));
            chk("m_gpio_oe", 64'(gpio_oe), 64'(ee));
            chk("m_irq", 64'(irq), 64'(m_irq));
            decode(address, hit, ch, rg);
            if (!tb_drive) begin
                if (read && !write && hit) begin
                    ed = 64'd0;
                    case (rg)
                        0: ed[W-1:0] = m_out[ch];
                        1: ed[W-1:0] = m_dir[ch];
                        2: ed[W-1:0] = h2[ch*W +: W];
                        3: ed[W-1:0] = m_evt[ch];
                        default: ed[W-1:0] = m_ien[ch];
                    endcase
                    chk("m_data", data, ed);
                end else begin
                    chk_hiz("m_data_idle", data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] v);
        address = a; tb_wdata = v; tb_drive = 1'b1; write = 1'b1; read = 1'b0;
        step(1);
        write = 1'b0; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [63:0] a, input logic [63:0] exp);
        address = a; read = 1'b1;
        #1 chk(name, data, exp);
        read = 1'b0;
        step(1);
    endtask

    task automatic bus_read_hiz(input string name, input logic [63:0] a);
        address = a; read = 1'b1;
        #1 chk_hiz(name, data);
        read = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1; gpio_in = '0; read = 1'b0; write = 1'b0;
        address = 64'd0; tb_drive = 1'b0; tb_wdata = 64'd0;
        step(2);
        reset = 1'b0;
        chk("rst_out", 64'(gpio_out), 64'd0);
        chk("rst_oe", 64'(gpio_oe), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk_hiz("rst_bus", data);
        step(2);

        // OUT / DIR writes and readback
        bus_write(64'hF000, 64'hA5);
        chk("out_a5", 64'(gpio_out[7:0]), 64'hA5);
        bus_write(64'hF001, 64'hFF);
        chk("oe_ff", 64'(gpio_oe[7:0]), 64'hFF);
        bus_read("rd_out", 64'hF000, 64'h0000_0000_0000_00A5);

        // Channel 1 pins 00->81: IN after 2 edges, EVT after 3
        gpio_in[15:8] = 8'h81;
        address = 64'hF00A; read = 1'b1;
        step(1);
        chk("in_e1", data, 64'h00);
        step(1);
        chk("in_e2", data, 64'h81);
        address = 64'hF00B;
        #1 chk("evt_e2", data, 64'h00);
        step(1);
        chk("evt_e3", data, 64'h81);
        chk("irq_noien", 64'(irq), 64'd0);
        read = 1'b0;
        step(1);

        // Interrupt enable and W1C
        bus_write(64'hF00C, 64'h01);
        chk("irq_lag", 64'(irq), 64'd0);
        step(1);
        chk("irq_set", 64'(irq), 64'd1);
        bus_write(64'hF00B, 64'h01);
        chk("irq_hold", 64'(irq), 64'd1);
        bus_read("evt_80", 64'hF00B, 64'h80);
        chk("irq_clr", 64'(irq), 64'd0);
        bus_write(64'hF00B, 64'h80);
        bus_read("evt_00", 64'hF00B, 64'h00);

        // W1C coinciding with a fresh rise on bit 0: set wins
        gpio_in[15:8] = 8'h80;
        step(4);
        gpio_in[15:8] = 8'h81;
        step(2);
        bus_write(64'hF00B, 64'h01);
        bus_read("evt_setwin", 64'hF00B, 64'h01);

        // Out-of-range accesses
        bus_read_hiz("rd_f020", 64'hF020);
        bus_read_hiz("rd_f005", 64'hF005);
        bus_read_hiz("rd_efff", 64'hEFFF);
        bus_write(64'hF020, 64'hFF);
        chk("nowr_out", 64'(gpio_out), 64'h0000_00A5);
        chk("nowr_oe", 64'(gpio_oe), 64'h0000_00FF);
        bus_read("nowr_rd", 64'hF000, 64'hA5);

        // Reset with all pins high and OUT=FF; no spurious events afterwards
        bus_write(64'hF000, 64'hFF);
        chk("out_ff", 64'(gpio_out[7:0]), 64'hFF);
        gpio_in = '1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rst2_out", 64'(gpio_out), 64'd0);
        chk("rst2_oe", 64'(gpio_oe), 64'd0);
        chk("rst2_irq", 64'(irq), 64'd0);
        for (int i = 0; i < 5; i++) begin
            bus_read("no_evt", 64'hF003 + 64'(8 * (i % 4)), 64'h00);
        end
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
